// File: rtl/conv_pe_line.sv
// conv_pe_line: systolic conv-layer processing element over a KSIZE-tap sliding ifmap window
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   en                global stall; low freezes every register
//   wgt_load, wgt_in  load the KSIZE-tap signed weight vector (tap i at [(i+1)*WGT_W-1 : i*WGT_W])
//   wgt_out           registered weight vector, forwarded to the next PE
//   ifmap_in/_valid   streamed ifmap sample; the valid also qualifies psum_in
//   line_start        first sample of a new row (restarts window fill)
//   ifmap_out/_valid  ifmap delayed by one accepted sample, forwarded to the next PE
//   psum_in           upstream partial sum
//   psum_out/_valid   psum_in + sum(w[i]*x[i]), registered one cycle after accept
//   sat_flag          result was clamped (always 0 unless saturation is built in)
//
// Build option: define CONV_PE_SAT_EN to clamp the result to the PSUM_W signed range
// instead of wrapping it.
module conv_pe_line #(
    parameter int KSIZE  = 3,
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int PSUM_W = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      wgt_load,
    input  logic [KSIZE*WGT_W-1:0]    wgt_in,
    output logic [KSIZE*WGT_W-1:0]    wgt_out,
    input  logic [DATA_W-1:0]         ifmap_in,
    input  logic                      ifmap_valid,
    input  logic                      line_start,
    output logic [DATA_W-1:0]         ifmap_out,
    output logic                      ifmap_out_valid,
    input  logic [PSUM_W-1:0]         psum_in,
    output logic [PSUM_W-1:0]         psum_out,
    output logic                      psum_valid,
    output logic                      sat_flag
);
    localparam int FILL_W = $clog2(KSIZE + 1);
    localparam int PROD_W = DATA_W + WGT_W;
    // Only KSIZE-1 history taps feed the window; keep at least one so ifmap_out exists for KSIZE=1.
    localparam int NT     = (KSIZE > 1) ? KSIZE - 1 : 1;
`ifdef CONV_PE_SAT_EN
    localparam int SUM_W  = PSUM_W + $clog2(KSIZE) + 1;
`else
    localparam int SUM_W  = PSUM_W;
`endif

    logic [NT-1:0][DATA_W-1:0]    taps_q;
    logic [KSIZE*WGT_W-1:0]       wgt_q;
    logic [FILL_W-1:0]            fill_q, fill_d;
    logic [PSUM_W-1:0]            psum_q, psum_d;
    logic                         vld_q, ov_q, sat_q, sat_d, full_d, accept;
    logic [KSIZE-1:0][DATA_W-1:0] win;
    logic signed [SUM_W-1:0]      acc;

    assign accept = en & ifmap_valid;

    // Newest sample enters the window combinationally; older ones come from the tap line.
    assign win[0] = ifmap_in;
    for (genvar k = 1; k < KSIZE; k++) begin : g_win
        assign win[k] = taps_q[k-1];
    end

    always_comb begin
        acc = SUM_W'($signed(psum_in));
        for (int i = 0; i < KSIZE; i++)
            acc = acc + SUM_W'(PROD_W'($signed(wgt_q[i*WGT_W +: WGT_W])) * PROD_W'($signed(win[i])));
    end

`ifdef CONV_PE_SAT_EN
    localparam logic signed [SUM_W-1:0] SMAX = (SUM_W'(1) <<< (PSUM_W - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SMIN = -SMAX - SUM_W'(1);
    always_comb begin
        sat_d  = (acc > SMAX) || (acc < SMIN);
        psum_d = (acc > SMAX) ? SMAX[PSUM_W-1:0] : (acc < SMIN) ? SMIN[PSUM_W-1:0] : acc[PSUM_W-1:0];
    end
`else
    assign sat_d  = 1'b0;
    assign psum_d = acc;
`endif

    // Fill saturates at KSIZE and only line_start or reset brings it back down.
    assign fill_d = line_start ? FILL_W'(1) : (fill_q == FILL_W'(KSIZE)) ? fill_q : fill_q + FILL_W'(1);
    assign full_d = (fill_d == FILL_W'(KSIZE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taps_q <= '0;
            wgt_q  <= '0;
            fill_q <= '0;
            psum_q <= '0;
            vld_q  <= 1'b0;
            ov_q   <= 1'b0;
            sat_q  <= 1'b0;
        end else if (en) begin
            if (wgt_load)
                wgt_q <= wgt_in;
            ov_q  <= ifmap_valid;
            vld_q <= ifmap_valid & full_d;
            if (ifmap_valid) begin
                taps_q[0] <= ifmap_in;
                for (int i = 1; i < NT; i++)
                    taps_q[i] <= taps_q[i-1];
                fill_q <= fill_d;
                psum_q <= psum_d;
                sat_q  <= sat_d & full_d;
            end
        end
    end

    assign wgt_out         = wgt_q;
    assign ifmap_out       = taps_q[0];
    assign ifmap_out_valid = ov_q;
    assign psum_out        = psum_q;
    assign psum_valid      = vld_q;
    assign sat_flag        = sat_q;
endmodule

// File: tb/tb_conv_pe_line.sv
// tb_conv_pe_line: directed vector bench for conv_pe_line (KSIZE=3, 8-bit data/weights, 20-bit psum)
module tb_conv_pe_line;
    localparam logic [23:0] W1 = 24'h030201;
    localparam logic [23:0] WM = 24'hFFFFFF;
    localparam logic [23:0] WN = 24'h010101;
`ifdef CONV_PE_SAT_EN
    localparam logic [19:0] OVF_P = 20'h7FFFF;
    localparam logic        OVF_S = 1'b1;
`else
    localparam logic [19:0] OVF_P = 20'h80063;
    localparam logic        OVF_S = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, wgt_load, ifmap_valid, line_start;
    logic [23:0] wgt_in, wgt_out;
    logic [7:0]  ifmap_in, ifmap_out;
    logic [19:0] psum_in, psum_out;
    logic        ifmap_out_valid, psum_valid, sat_flag;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    conv_pe_line #(.KSIZE(3), .DATA_W(8), .WGT_W(8), .PSUM_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wgt_load(wgt_load), .wgt_in(wgt_in),
        .wgt_out(wgt_out), .ifmap_in(ifmap_in), .ifmap_valid(ifmap_valid),
        .line_start(line_start), .ifmap_out(ifmap_out), .ifmap_out_valid(ifmap_out_valid),
        .psum_in(psum_in), .psum_out(psum_out), .psum_valid(psum_valid), .sat_flag(sat_flag)
    );

    typedef struct {
        logic        ld;
        logic [23:0] w;
        logic        v;
        logic        ls;
        logic [7:0]  x;
        logic [19:0] p;
        logic        cp;
        logic        ev;
        logic [19:0] ep;
        logic        eov;
        logic [7:0]  ex;
        logic [23:0] ew;
        logic        es;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ld, logic [23:0] w, logic v, logic ls, logic [7:0] x,
                                logic [19:0] p, logic cp, logic ev, logic [19:0] ep,
                                logic eov, logic [7:0] ex, logic [23:0] ew, logic es);
        vec_t r;
        r.ld = ld; r.w = w; r.v = v; r.ls = ls; r.x = x; r.p = p; r.cp = cp;
        r.ev = ev; r.ep = ep; r.eov = eov; r.ex = ex; r.ew = ew; r.es = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic r, input logic ld, input logic [23:0] w,
                       input logic v, input logic ls, input logic [7:0] x, input logic [19:0] p);
        en = e; rst_n = r; wgt_load = ld; wgt_in = w;
        ifmap_valid = v; line_start = ls; ifmap_in = x; psum_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [19:0] ep, input logic eov,
                           input logic [7:0] ex, input logic [23:0] ew, input logic es);
        chk({tag, ".psum_valid"}, 32'(psum_valid), 32'(ev));
        chk({tag, ".psum_out"}, 32'(psum_out), 32'(ep));
        chk({tag, ".ifmap_out_valid"}, 32'(ifmap_out_valid), 32'(eov));
        chk({tag, ".ifmap_out"}, 32'(ifmap_out), 32'(ex));
        chk({tag, ".wgt_out"}, 32'(wgt_out), 32'(ew));
        chk({tag, ".sat_flag"}, 32'(sat_flag), 32'(es));
    endtask

    initial begin
        // basic row, 100 then 165, then a hold cycle
        tbl.push_back(mk(1, W1, 0, 0, 8'd0,  20'd0, 1, 0, 20'd0,   0, 8'd0,  W1, 0));
        tbl.push_back(mk(0, 0,  1, 1, 8'd10, 20'd0, 0, 0, 20'd0,   1, 8'd10, W1, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd20, 20'd0, 0, 0, 20'd0,   1, 8'd20, W1, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd30, 20'd0, 1, 1, 20'd100, 1, 8'd30, W1, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd40, 20'd5, 1, 1, 20'd165, 1, 8'd40, W1, 0));
        tbl.push_back(mk(0, 0,  0, 0, 8'd0,  20'd0, 1, 0, 20'd165, 0, 8'd40, W1, 0));
        // line restart from a full window
        tbl.push_back(mk(0, 0,  1, 1, 8'd1,  20'd0, 0, 0, 20'd0,   1, 8'd1,  W1, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd2,  20'd0, 0, 0, 20'd0,   1, 8'd2,  W1, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd3,  20'd0, 1, 1, 20'd10,  1, 8'd3,  W1, 0));
        // signed arithmetic with -1 weights
        tbl.push_back(mk(1, WM, 0, 0, 8'd0,  20'd0, 1, 0, 20'd10,  0, 8'd3,  WM, 0));
        tbl.push_back(mk(0, 0,  1, 1, 8'h80, 20'd0, 0, 0, 20'd0,   1, 8'h80, WM, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'h80, 20'd0, 0, 0, 20'd0,   1, 8'h80, WM, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'h80, 20'd0, 1, 1, 20'h00180, 1, 8'h80, WM, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'h7F, 20'd0, 1, 1, 20'h00081, 1, 8'h7F, WM, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'h7F, 20'd0, 1, 1, 20'hFFF82, 1, 8'h7F, WM, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'h7F, 20'd0, 1, 1, 20'hFFE83, 1, 8'h7F, WM, 0));
        // weight load coinciding with an accept uses the old weights
        tbl.push_back(mk(1, W1, 0, 0, 8'd0,  20'd0, 1, 0, 20'hFFE83, 0, 8'h7F, W1, 0));
        tbl.push_back(mk(0, 0,  1, 1, 8'd1,  20'd0, 0, 0, 20'd0,   1, 8'd1,  W1, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd1,  20'd0, 0, 0, 20'd0,   1, 8'd1,  W1, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd1,  20'd0, 1, 1, 20'd6,   1, 8'd1,  W1, 0));
        tbl.push_back(mk(1, WN, 1, 0, 8'd2,  20'd0, 1, 1, 20'd7,   1, 8'd2,  WN, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd3,  20'd0, 1, 1, 20'd6,   1, 8'd3,  WN, 0));
        // overflow: products sum to +100 on top of the largest positive psum
        tbl.push_back(mk(0, 0,  1, 1, 8'd30, 20'd0, 0, 0, 20'd0,   1, 8'd30, WN, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd30, 20'd0, 0, 0, 20'd0,   1, 8'd30, WN, 0));
        tbl.push_back(mk(0, 0,  1, 0, 8'd40, 20'h7FFFF, 1, 1, OVF_P, 1, 8'd40, WN, OVF_S));
        tbl.push_back(mk(0, 0,  1, 0, 8'd0,  20'd0, 1, 1, 20'h46,  1, 8'd0,  WN, 0));
        tbl.push_back(mk(0, 0,  0, 0, 8'd0,  20'd0, 1, 0, 20'h46,  0, 8'd0,  WN, 0));

        cyc(1, 0, 1, W1, 1, 1, 8'h55, 20'h12345);
        cyc(1, 0, 1, W1, 1, 1, 8'h55, 20'h12345);
        chk_all("reset", 0, 20'd0, 0, 8'd0, 24'd0, 0);

        foreach (tbl[i]) begin
            cyc(1, 1, tbl[i].ld, tbl[i].w, tbl[i].v, tbl[i].ls, tbl[i].x, tbl[i].p);
            chk($sformatf("vec%0d.psum_valid", i), 32'(psum_valid), 32'(tbl[i].ev));
            if (tbl[i].cp)
                chk($sformatf("vec%0d.psum_out", i), 32'(psum_out), 32'(tbl[i].ep));
            chk($sformatf("vec%0d.ifmap_out_valid", i), 32'(ifmap_out_valid), 32'(tbl[i].eov));
            chk($sformatf("vec%0d.ifmap_out", i), 32'(ifmap_out), 32'(tbl[i].ex));
            chk($sformatf("vec%0d.wgt_out", i), 32'(wgt_out), 32'(tbl[i].ew));
            chk($sformatf("vec%0d.sat_flag", i), 32'(sat_flag), 32'(tbl[i].es));
        end

        // stall: window 0,40,30 with unit weights; accept 10 -> 50, then freeze four cycles
        cyc(1, 1, 0, 24'd0, 1, 0, 8'd10, 20'd0);
        chk_all("stall_pre", 1, 20'd50, 1, 8'd10, WN, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1, WM, 1, 1, 8'd99, 20'd777);
            chk_all($sformatf("stall%0d", i), 1, 20'd50, 1, 8'd10, WN, 0);
        end
        cyc(1, 1, 0, 24'd0, 1, 0, 8'd20, 20'd0);
        chk_all("stall_post", 1, 20'd30, 1, 8'd20, WN, 0);

        // reset with fill=2 clears weights and window; refill needs three accepts
        cyc(1, 1, 0, 24'd0, 1, 1, 8'd1, 20'd0);
        cyc(1, 1, 0, 24'd0, 1, 0, 8'd2, 20'd0);
        cyc(1, 0, 0, 24'd0, 1, 0, 8'd5, 20'd9);
        chk_all("rst_mid", 0, 20'd0, 0, 8'd0, 24'd0, 0);
        cyc(1, 1, 1, W1, 1, 0, 8'd1, 20'd0);
        chk("refill1.psum_valid", 32'(psum_valid), 32'd0);
        cyc(1, 1, 0, 24'd0, 1, 0, 8'd2, 20'd0);
        chk("refill2.psum_valid", 32'(psum_valid), 32'd0);
        cyc(1, 1, 0, 24'd0, 1, 0, 8'd3, 20'd0);
        chk_all("refill3", 1, 20'd10, 1, 8'd3, W1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_pe_line.md
Name: conv_pe_line

Overview:
- Parametrised successor to the conv-layer processing element.
- Holds a KSIZE-tap sliding window of the streamed ifmap row and a locally loaded KSIZE-tap signed weight vector. Computes psum_out = psum_in + sum(w[i]*x[i]) with a valid qualifier.
- Forwards delayed ifmap and registered weights to the next PE, so PEs chain as a systolic column.
- Adds what the previous PE lacked: window-fill tracking, line restart, valid handshake, global stall and optional saturation.

Parameters:
- KSIZE, 3, number of kernel taps (>=1).
- DATA_W, 8, signed ifmap sample width.
- WGT_W, 8, signed weight width per tap.
- PSUM_W, 20, signed partial-sum width (>= DATA_W+WGT_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  global stall; low = every register holds.
- wgt_load  in  1  load wgt_in into the weight register.
- wgt_in  in  KSIZE*WGT_W  weights; tap i at [(i+1)*WGT_W-1 : i*WGT_W].
- wgt_out  out  KSIZE*WGT_W  registered weight vector, forwarded to the next PE.
- ifmap_in  in  DATA_W  ifmap sample.
- ifmap_valid  in  1  ifmap_in/psum_in valid this cycle.
- line_start  in  1  qualifies first sample of a new row; only meaningful with ifmap_valid.
- ifmap_out  out  DATA_W  tap[0], i.e. ifmap_in delayed one accepted sample.
- ifmap_out_valid  out  1  registered en&ifmap_valid.
- psum_in  in  PSUM_W  upstream partial sum, sampled with ifmap_valid.
- psum_out  out  PSUM_W  registered result.
- psum_valid  out  1  psum_out valid.
- sat_flag  out  1  result clamped this cycle (0 without macro).

Behaviour:
- Reset (rst_n=0 at posedge): taps, weight reg, fill count, and all outputs go to 0. Takes priority over en; mid-operation it discards the window and requires a refill.
- en=0: all state and outputs hold, including psum_valid.
- Accept = en & ifmap_valid.
- On accept:
  - tap[0]<=ifmap_in, tap[i]<=tap[i-1].
  - fill<=line_start ? 1 : min(fill+1, KSIZE). fill width is clog2(KSIZE+1).
- Compute window (combinational, on accept): x[0]=ifmap_in (newest); x[i]=tap[i-1] for i>=1. On line_start, x[i>=1] are stale, but the result is not flagged valid unless KSIZE=1.
- Result: registered 1 cycle after accept.
  - psum_out <= psum_in + sum over i of $signed(w[i])*$signed(x[i]).
  - Each product is DATA_W+WGT_W signed, sign-extended.
  - Without the macro, the sum wraps modulo 2^PSUM_W.
- psum_valid <= accept & (next fill == KSIZE). Without accept (and en=1), psum_valid <= 0 and psum_out holds.
- Steady state: one valid result per accepted sample after the first KSIZE-1 samples of a row.
- ifmap_out_valid <= accept when en=1.
- Weights: when en & wgt_load, wgt_reg <= wgt_in, and wgt_out = wgt_reg is visible the next cycle.
- wgt_load and accept in the same cycle: that computation uses the OLD weights; the new weights apply from the next accept.
- No FSM beyond the fill counter: states are EMPTY (fill=0), FILLING (0<fill<KSIZE), FULL (fill=KSIZE). FULL persists until line_start or reset.

Optional Feature:
- Macro: CONV_PE_SAT_EN.
- Defined:
  - Sum is computed at PSUM_W+clog2(KSIZE)+1 bits and clamped to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
  - sat_flag <= 1 with a valid result when clamping occurred; otherwise 0, and updated only on accept.
- Undefined: two's-complement wrap; sat_flag tied 0.

Test Plan:
- Setup: KSIZE=3, DATA_W=8, WGT_W=8, PSUM_W=20, wgt_in=24'h030201 loaded.
- Basic row: line_start on sample 10, then samples 20, 30, psum_in=0 -> psum_valid low for the first two; after 30, psum_out=30*1+20*2+10*3=100, valid 1 cycle later. Next sample 40 with psum_in=5 -> 40+60+60+5=165.
- Signed: weights 24'hFFFFFF (-1 each), three samples 8'h80 -> psum_out=384 (20'h00180). Then samples 8'h7F x3 -> -381 (20'hFFE83).
- Line restart: after the window is FULL, line_start on the next sample -> psum_valid stays 0 for 2 accepts and returns on the 3rd. ifmap_out_valid follows every accept.
- Stall/weights:
  - en=0 for 4 cycles mid-row -> all outputs frozen and no extra valid.
  - wgt_load with new weights 24'h010101 in the same cycle as an accept -> that result uses the old weights; the next result uses the new ones; wgt_out updates 1 cycle after the load.
- Reset mid-row: rst_n=0 for one cycle with fill=2 -> all outputs 0; the next 2 accepts give no valid, and the 3rd gives valid.
- Overflow: psum_in=20'h7FFFF, window products summing to +100.
  - With CONV_PE_SAT_EN: psum_out=20'h7FFFF, sat_flag=1.
  - Without: psum_out=20'h80063, sat_flag=0.
